// File: rtl/axi_pkg.sv
// Shared definitions for the single-outstanding AXI initiator.
//   state_e     : initiator FSM states
//   RESP_*      : AXI response codes used by the initiator
//   REG_COUNT / CRC_ADDR : register map of the attached register-file slave
//   resp_sel()  : folds a protocol-error flag into a captured response
package axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int         REG_COUNT = 8;
    localparam logic [7:0] CRC_ADDR  = 8'h20;

    // A protocol error (wrong ID, missing last) overrides whatever the slave said.
    function automatic logic [1:0] resp_sel(input logic err, input logic [1:0] resp);
        return err ? RESP_SLVERR : resp;
    endfunction

endpackage

// File: rtl/axi_wr_issue.sv
// Write-request issue: drives the AW and W valid pair of one write.
// Each channel has its own done flag so the handshakes may complete in any
// order or in the same cycle; a valid drops after its own handshake and is
// not raised again until the next start.
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   start_i                : pulse on command accept (write)
//   awready_i, wready_i    : AXI ready inputs
//   awvalid_o, wvalid_o    : registered AXI valids
//   both_done_o            : both handshakes done (including this cycle's)
module axi_wr_issue (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic awready_i,
    input  logic wready_i,
    output logic awvalid_o,
    output logic wvalid_o,
    output logic both_done_o
);

    logic awvalid_q, awvalid_d;
    logic wvalid_q,  wvalid_d;
    logic aw_done_q, aw_done_d;
    logic w_done_q,  w_done_d;
    logic aw_hs, w_hs;

    assign aw_hs = awvalid_q & awready_i;
    assign w_hs  = wvalid_q & wready_i;

    always_comb begin
        awvalid_d = awvalid_q & ~aw_hs;
        wvalid_d  = wvalid_q & ~w_hs;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (start_i) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Looking at this cycle's handshakes lets the FSM leave WR_REQ on the
    // same edge the last handshake completes.
    assign both_done_o = (aw_done_q | aw_hs) & (w_done_q | w_hs);
    assign awvalid_o   = awvalid_q;
    assign wvalid_o    = wvalid_q;

endmodule

// File: rtl/m_axi_master.sv
// Single-outstanding AXI initiator. A valid/ready command becomes one
// single-beat AXI write or read; one response word is returned per command.
//   clk, areset (sync, active low)
//   cmd_*   : command port (valid/ready, write flag, addr, data, strobes)
//   rsp_*   : response port (valid/ready, read data, response code)
//   aw*/w*/b*/ar*/r* : AXI initiator channels; IDs are the constant TXN_ID
// Every output comes straight from a flop (or is constant).
module m_axi_master
    import axi_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter int         ADDR_WIDTH = 32,
    parameter logic [3:0] TXN_ID     = 4'h0
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic [3:0]              awid_o,
    output logic [ADDR_WIDTH-1:0]   awaddr_o,
    output logic                    awvalid_o,
    input  logic                    awready_i,
    output logic [3:0]              wid_o,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [DATA_WIDTH/8-1:0] wstrb_o,
    output logic                    wlast_o,
    output logic                    wvalid_o,
    input  logic                    wready_i,
    input  logic [3:0]              bid_i,
    input  logic [1:0]              bresp_i,
    input  logic                    bvalid_i,
    output logic                    bready_o,
    output logic [3:0]              arid_o,
    output logic [ADDR_WIDTH-1:0]   araddr_o,
    output logic                    arvalid_o,
    input  logic                    arready_i,
    input  logic [3:0]              rid_i,
    input  logic [DATA_WIDTH-1:0]   rdata_i,
    input  logic                    rlast_i,
    input  logic                    rvalid_i,
    output logic                    rready_o
);

    state_e                    state_q, state_d;
    logic                      cmd_ready_q, cmd_ready_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
    logic                      arvalid_q, arvalid_d;
    logic                      bready_q, bready_d;
    logic                      rready_q, rready_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                rsp_resp_q, rsp_resp_d;
    logic                      wr_start;
    logic                      wr_both_done;
    logic                      awvalid_w, wvalid_w;

    axi_wr_issue u_wr_issue (
        .clk_i       (clk),
        .rst_ni      (areset),
        .start_i     (wr_start),
        .awready_i   (awready_i),
        .wready_i    (wready_i),
        .awvalid_o   (awvalid_w),
        .wvalid_o    (wvalid_w),
        .both_done_o (wr_both_done)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        wr_start    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        wr_start = 1'b1;
                        state_d  = ST_WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_REQ;
                    end
                end
            end
            ST_WR_REQ: begin
                if (wr_both_done) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (bvalid_i && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = resp_sel(bid_i != TXN_ID, bresp_i);
                    state_d     = ST_RSP;
                end
            end
            ST_RD_REQ: begin
                if (arvalid_q && arready_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (rvalid_i && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rdata_i;
                    // The slave has no rresp; the only error source is us.
                    rsp_resp_d  = resp_sel((rid_i != TXN_ID) || !rlast_i, RESP_OKAY);
                    state_d     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered ready that reflects where the FSM will be next cycle.
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!areset) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

    assign awid_o    = TXN_ID;
    assign wid_o     = TXN_ID;
    assign arid_o    = TXN_ID;
    assign awaddr_o  = addr_q;
    assign araddr_o  = addr_q;
    assign awvalid_o = awvalid_w;
    assign wdata_o   = wdata_q;
    assign wstrb_o   = wstrb_q;
    assign wvalid_o  = wvalid_w;
    assign wlast_o   = wvalid_w;   // single beat: every W beat is the last
    assign bready_o  = bready_q;
    assign arvalid_o = arvalid_q;
    assign rready_o  = rready_q;

endmodule

// File: tb/tb_m_axi_master.sv
module tb_m_axi_master;
    import axi_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
    } rsp_t;

    logic          clk = 1'b0;
    logic          areset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [3:0]    awid_o, wid_o, arid_o;
    logic [AW-1:0] awaddr_o, araddr_o;
    logic          awvalid_o, awready_i;
    logic [DW-1:0] wdata_o;
    logic [3:0]    wstrb_o;
    logic          wlast_o, wvalid_o, wready_i;
    logic [3:0]    bid_i;
    logic [1:0]    bresp_i;
    logic          bvalid_i, bready_o;
    logic          arvalid_o, arready_i;
    logic [3:0]    rid_i;
    logic [DW-1:0] rdata_i;
    logic          rlast_i, rvalid_i, rready_o;

    always #5 clk = ~clk;

    m_axi_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TXN_ID(4'h0)) dut (
        .clk(clk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rid_i(rid_i), .rdata_i(rdata_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    rsp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- bench slave: register file + checksum ----------------
    bit         rnd_mode = 0;
    bit         b_hold = 0;
    int         aw_low_req = 0;
    logic [3:0] bid_val = 4'h0, rid_val = 4'h0;
    bit         rlast_val = 1;
    logic [31:0] smem [REG_COUNT];
    logic        got_aw, got_w;
    logic [AW-1:0] s_awaddr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    int          aw_wait_cnt;
    logic        aw_rnd, w_rnd, ar_rnd;

    assign awready_i = (aw_wait_cnt >= aw_low_req) && (!rnd_mode || aw_rnd);
    assign wready_i  = !rnd_mode || w_rnd;
    assign arready_i = !rnd_mode || ar_rnd;

    function automatic logic [31:0] srd(input logic [AW-1:0] a);
        logic [31:0] x;
        x = 32'h0;
        if (a[7:0] == CRC_ADDR) begin
            for (int i = 0; i < REG_COUNT; i++) x = x ^ smem[i];
        end else begin
            x = smem[a[4:2]];
        end
        return x;
    endfunction

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        aw_rnd <= 1'($urandom % 2);
        w_rnd  <= 1'($urandom % 2);
        ar_rnd <= 1'($urandom % 2);
        if (!areset) begin
            for (int i = 0; i < REG_COUNT; i++) smem[i] <= 32'h0;
            got_aw <= 1'b0; got_w <= 1'b0;
            bvalid_i <= 1'b0; rvalid_i <= 1'b0;
            bid_i <= 4'h0; bresp_i <= 2'b00; rid_i <= 4'h0; rdata_i <= 32'h0; rlast_i <= 1'b0;
            aw_wait_cnt <= 0;
            s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0;
        end else begin
            if (awvalid_o && !awready_i) aw_wait_cnt <= aw_wait_cnt + 1;
            else aw_wait_cnt <= 0;
            if (awvalid_o && awready_i) begin got_aw <= 1'b1; s_awaddr <= awaddr_o; end
            if (wvalid_o && wready_i) begin got_w <= 1'b1; s_wdata <= wdata_o; s_wstrb <= wstrb_o; end
            if (got_aw && got_w && !bvalid_i && !b_hold) begin
                if (s_awaddr[7:0] < CRC_ADDR)
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) smem[s_awaddr[4:2]][8*b +: 8] <= s_wdata[8*b +: 8];
                bvalid_i <= 1'b1; bid_i <= bid_val; bresp_i <= RESP_OKAY;
                got_aw <= 1'b0; got_w <= 1'b0;
            end
            if (bvalid_i && bready_o) bvalid_i <= 1'b0;
            if (arvalid_o && arready_i) begin
                rvalid_i <= 1'b1; rdata_i <= srd(araddr_o); rid_i <= rid_val; rlast_i <= rlast_val;
            end
            if (rvalid_i && rready_o) rvalid_i <= 1'b0;
        end
    end

    // ---------------- reference model: register map with checksum ----------------
    logic [31:0] mdl [REG_COUNT];

    task automatic model_exec(input bit w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input bit err, output rsp_t e);
        e.rdata = 32'h0;
        if (w) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[a[4:2]][8*b +: 8] = d[8*b +: 8];
        end else if (a[7:0] == CRC_ADDR) begin
            for (int i = 0; i < REG_COUNT; i++) e.rdata = e.rdata ^ mdl[i];
        end else begin
            e.rdata = mdl[a[4:2]];
        end
        e.resp = err ? RESP_SLVERR : RESP_OKAY;
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit            hold_rsp = 0;
    int            rsp_rise_cyc = 0;
    int            n_awv = 0, n_wv = 0, n_bhs = 0;
    logic          prev_rsp_valid = 1'b0;
    logic          prev_aw_stall = 1'b0, prev_w_stall = 1'b0, prev_ar_stall = 1'b0;
    logic [AW-1:0] prev_awaddr, prev_araddr;
    logic [DW-1:0] prev_wdata;

    initial rsp_ready = 1'b0;

    always @(negedge clk) begin
        rsp_t e;
        if (!areset) begin
            rsp_ready = 1'b0;
            prev_rsp_valid = 1'b0;
            prev_aw_stall = 1'b0; prev_w_stall = 1'b0; prev_ar_stall = 1'b0;
        end else begin
            rsp_ready = hold_rsp ? 1'b0 : (rnd_mode ? ($urandom % 4 != 0) : 1'b1);
            if (rsp_valid && !prev_rsp_valid) rsp_rise_cyc = cyc;
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL rsp_unexpected: got rdata %0h with no command outstanding", rsp_rdata);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_resp", rsp_resp, e.resp);
                end
            end
            if (prev_aw_stall) begin
                chk("awvalid_held", awvalid_o, 1);
                chk("awaddr_stable", awaddr_o, prev_awaddr);
            end
            if (prev_w_stall) begin
                chk("wvalid_held", wvalid_o, 1);
                chk("wdata_stable", wdata_o, prev_wdata);
            end
            if (prev_ar_stall) begin
                chk("arvalid_held", arvalid_o, 1);
                chk("araddr_stable", araddr_o, prev_araddr);
            end
            if (wvalid_o) chk("wlast", wlast_o, 1);
            prev_aw_stall = awvalid_o && !awready_i;
            prev_w_stall  = wvalid_o && !wready_i;
            prev_ar_stall = arvalid_o && !arready_i;
            prev_awaddr = awaddr_o; prev_araddr = araddr_o; prev_wdata = wdata_o;
            if (awvalid_o) n_awv++;
            if (wvalid_o) n_wv++;
            if (bvalid_i && bready_o) n_bhs++;
            prev_rsp_valid = rsp_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_cmd(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit err, output int acc_cyc);
        rsp_t e;
        int   n;
        model_exec(w, a, d, s, err, e);
        sb.push_back(e);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        n = 0;
        while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) begin
            n_vec++; n_bad++;
            $display("FAIL cmd_accept_timeout: cmd_ready %0b after %0d cycles, required 1", cmd_ready, n);
        end
        acc_cyc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb.size() != 0 || !cmd_ready) && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) begin
            n_vec++; n_bad++;
            $display("FAIL rsp_timeout: %0d responses pending, required 0", sb.size());
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_awvalid"}, awvalid_o, 0);
        chk({tag, "_wvalid"}, wvalid_o, 0);
        chk({tag, "_arvalid"}, arvalid_o, 0);
        chk({tag, "_bready"}, bready_o, 0);
        chk({tag, "_rready"}, rready_o, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
    endtask

    initial begin
        int acc, a0, w0, b0, n;
        rsp_t e;
        for (int i = 0; i < REG_COUNT; i++) mdl[i] = 32'h0;
        areset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_awaddr", awaddr_o, 0);
        chk("reset_wdata", wdata_o, 0);
        chk("reset_wstrb", wstrb_o, 0);
        chk("reset_wlast", wlast_o, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_resp", rsp_resp, 0);
        areset = 1'b1;
        @(negedge clk);
        chk("release_cmd_ready", cmd_ready, 1);

        // basic write then read-back, with best-case latency
        do_cmd(1, 32'h04, 32'hDEADBEEF, 4'hF, 0, acc);
        wait_done();
        chk("wr_latency_ge4", (rsp_rise_cyc - acc >= 4) ? 1 : 0, 1);
        do_cmd(0, 32'h04, 32'h0, 4'h0, 0, acc);
        wait_done();
        chk("rd_latency", rsp_rise_cyc - acc, 3);

        // partial strobes over zero
        do_cmd(1, 32'h08, 32'h0, 4'hF, 0, acc);
        do_cmd(1, 32'h08, 32'h11223344, 4'b0101, 0, acc);
        do_cmd(0, 32'h08, 32'h0, 4'h0, 0, acc);
        wait_done();

        // checksum: 1 ^ 2 ^ 4 with everything else zero
        for (int i = 0; i < REG_COUNT; i++) do_cmd(1, 32'(i * 4), 32'h0, 4'hF, 0, acc);
        do_cmd(1, 32'h00, 32'h1, 4'hF, 0, acc);
        do_cmd(1, 32'h04, 32'h2, 4'hF, 0, acc);
        do_cmd(1, 32'h08, 32'h4, 4'hF, 0, acc);
        do_cmd(0, 32'h20, 32'h0, 4'h0, 0, acc);
        wait_done();

        // AW backpressure with W ready
        a0 = n_awv; w0 = n_wv; b0 = n_bhs;
        aw_low_req = 3;
        do_cmd(1, 32'h0C, 32'hCAFE0123, 4'hF, 0, acc);
        wait_done();
        aw_low_req = 0;
        chk("bp_awvalid_cycles", n_awv - a0, 4);
        chk("bp_wvalid_cycles", n_wv - w0, 1);
        chk("bp_b_handshakes", n_bhs - b0, 1);

        // response held off for 5 cycles
        hold_rsp = 1;
        do_cmd(0, 32'h0C, 32'h0, 4'h0, 0, acc);
        e = sb[sb.size() - 1];
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        for (int k = 0; k < 5; k++) begin
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_rdata", rsp_rdata, e.rdata);
            chk("hold_cmd_ready", cmd_ready, 0);
            @(negedge clk);
        end
        hold_rsp = 0;
        wait_done();

        // protocol errors
        rid_val = 4'h3;
        do_cmd(0, 32'h04, 32'h0, 4'h0, 1, acc);
        wait_done();
        rid_val = 4'h0;
        bid_val = 4'h5;
        do_cmd(1, 32'h14, 32'h5A5A5A5A, 4'hF, 1, acc);
        wait_done();
        bid_val = 4'h0;
        rlast_val = 0;
        do_cmd(0, 32'h14, 32'h0, 4'h0, 1, acc);
        wait_done();
        rlast_val = 1;

        // randomized traffic with random slave/consumer backpressure
        rnd_mode = 1;
        for (int i = 0; i < 150; i++) begin
            bit          w, err;
            logic [31:0] a;
            w = 1'($urandom % 2);
            a = w ? 32'(($urandom % 8) * 4) : 32'(($urandom % 9) * 4);
            err = ($urandom % 10 == 0);
            if (err) begin
                wait_done();
                if (w) bid_val = 4'h9; else rid_val = 4'h3;
            end
            do_cmd(w, a, $urandom, 4'($urandom % 16), err, acc);
            if (err) begin
                wait_done();
                bid_val = 4'h0; rid_val = 4'h0;
            end
        end
        wait_done();
        rnd_mode = 0;

        // reset while waiting for B
        b_hold = 1;
        do_cmd(1, 32'h10, 32'h12345678, 4'hF, 0, acc);
        n = 0;
        while (!bready_o && n < 100) begin @(negedge clk); n++; end
        chk("wr_resp_bready", bready_o, 1);
        areset = 1'b0;
        @(negedge clk);
        chk_idle_outputs("midreset");
        sb.delete();
        for (int i = 0; i < REG_COUNT; i++) mdl[i] = 32'h0;
        b_hold = 0;
        areset = 1'b1;
        @(negedge clk);
        chk("post_reset_cmd_ready", cmd_ready, 1);
        do_cmd(0, 32'h10, 32'h0, 4'h0, 0, acc);
        wait_done();
        chk("post_reset_rd_latency", rsp_rise_cyc - acc, 3);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/m_axi_master.md
# m_axi_master

Single-outstanding AXI initiator that turns a simple valid/ready command port into single-beat AXI write or read transactions. It drives the register-file slave (8 × 32-bit words at byte addresses 0x00–0x1C, XOR checksum at 0x20) from a local controller or testbench sequencer. It also returns a one-word response per command.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address bus width.
- TXN_ID, 4'h0, constant ID driven on awid/wid/arid and expected on bid/rid.

Ports:
- clk  in  1  the only clock; all logic on its rising edge.
- areset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  4  byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  captured bresp/rresp, or SLVERR on protocol error.
- awid_o, awaddr_o, awvalid_o / awready_i: AXI write address channel, widths as slave.
- wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o / wready_i: AXI write data channel.
- bid_i, bresp_i, bvalid_i / bready_o: AXI write response channel.
- arid_o, araddr_o, arvalid_o / arready_i: AXI read address channel.
- rid_i, rdata_i, rlast_i, rvalid_i / rready_o: AXI read data channel.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: cmd_ready=1. On accept, all command fields are latched, and the FSM moves to WR_REQ or RD_REQ according to cmd_write.
- WR_REQ: awvalid_o and wvalid_o are asserted together. Each channel has an independent done flag.
  - A valid drops in the cycle after its own handshake and never re-asserts.
  - The FSM moves to WR_RESP once both flags are set. Both handshakes may complete in the same cycle.
  - wlast_o=1 whenever wvalid_o=1.
- WR_RESP: bready_o=1. On the bvalid_i handshake, bresp_i is captured, rsp_rdata is set to 0, and the FSM moves to RSP.
- RD_REQ: arvalid_o=1 until the handshake, then the FSM moves to RD_DATA.
- RD_DATA: rready_o=1. On the rvalid_i handshake, rdata_i and rresp are captured, and the FSM moves to RSP. The slave has no rresp port, so rresp is taken as OKAY (2'b00).
- RSP: rsp_valid=1 and the response is held stable until rsp_ready. The FSM then returns to IDLE.
- Protocol error: rsp_resp is forced to SLVERR (2'b10) in either case below.
  - bid_i≠TXN_ID or rid_i≠TXN_ID at the handshake.
  - rlast_i=0 at the read handshake.
- Once asserted, valid outputs hold their address/data stable until the handshake (AXI rule). valid is never gated on ready.
- Only one transaction is outstanding. No timeout; the FSM waits indefinitely.

## Timing
- All outputs are registered.
- Reset values:
  - cmd_ready=0 during reset; 1 in the first cycle after release.
  - All *valid_o, bready_o, rready_o, rsp_valid = 0.
  - Address, data, strobe and response outputs = 0.
  - wlast_o=0.
- Best-case latency, with accept at cycle 0 and the slave always ready:
  - Write: AW/W valid at cycle 1; B handshake at cycle 3 (the slave asserts bvalid after it has both address and data); rsp_valid no earlier than cycle 4.
  - Read: arvalid at cycle 1; R handshake at cycle 2; rsp_valid at cycle 3.
- cmd_ready is 0 from the cycle after accept until the cycle after the rsp handshake.
- rsp_valid && rsp_ready → IDLE in the next cycle, so back-to-back commands occur at most every N+1 cycles.
- Reset mid-transaction: all valids drop at the next edge and the FSM goes to IDLE. The attached slave must be reset together with this block.
- Ready inputs asserted before the corresponding valid are ignored until the valid is high.

## Structure
- Shared package axi_pkg contains:
  - the state enum (typedef enum logic [2:0]);
  - resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - the register map constants: REG_COUNT=8, CRC_ADDR=8'h20.
- One natural sub-module, axi_wr_issue: it holds the AW/W valid pair with independent done flags and emits both_done. The read path stays inline.

## Test plan
- Reset release, then write 0xDEADBEEF to 0x04 with wstrb 4'hF → rsp_resp=00 and rsp_rdata=0. Reading 0x04 then returns 0xDEADBEEF.
- Write 0x11223344 to 0x08 with wstrb 4'b0101 over a previous value of 0 → reading 0x08 returns 0x00220044.
- Write 0x1 to 0x00, 0x2 to 0x04 and 0x4 to 0x08 (others 0) → reading 0x20 returns 0x00000007.
- Backpressure: awready_i held low 3 cycles while wready_i=1 → wvalid_o drops after 1 cycle, awvalid_o holds for 4, and exactly one B handshake occurs.
- Hold rsp_ready low for 5 cycles → rsp_valid and rsp_rdata stay stable and cmd_ready stays 0. A bench slave driving rid_i=4'h3 → rsp_resp=2'b10.
- Assert areset low while in WR_RESP → the next cycle shows all valids=0 and cmd_ready=0; release gives cmd_ready=1 and a clean new read.
